systolic_pe: RTL
================

# systolic_pe

Parametrised output-stationary processing element for the systolic matrix-multiply array. It forwards A operands east and B operands south with valid tags, and performs a signed or unsigned multiply-accumulate into a wide, optionally saturating accumulator. Results drain through a per-column shift chain. The drain overlaps the next tile's accumulation, so the array never stalls while results are read out.

## Interface
- `DATA_WIDTH`, default 16: A/B operand width.
- `ACC_WIDTH`, default 40: accumulator and result width; must be ≥ 2*DATA_WIDTH.
- `SIGNED`, default 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- `SATURATE`, default 1: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH.
- `CHAIN_LEN`, default 0: number of PEs above this one in the drain chain.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_in` in DATA_WIDTH, `a_valid_in` in 1: west operand.
- `b_in` in DATA_WIDTH, `b_valid_in` in 1: north operand.
- `clear` in 1: zero the accumulator and overflow flag.
- `drain` in 1: one-cycle pulse; emit own result, then forward the chain.
- `c_in` in ACC_WIDTH, `c_valid_in` in 1, `c_ovf_in` in 1: result from the PE above.
- `a_out` out DATA_WIDTH, `a_valid_out` out 1: registered copy of A to the east.
- `b_out` out DATA_WIDTH, `b_valid_out` out 1: registered copy of B to the south.
- `c_out` out ACC_WIDTH, `c_valid_out` out 1, `c_ovf_out` out 1: result to the PE below.
- `busy` out 1: high while in DRAIN.

## Operation
- **Reset:** all outputs 0, accumulator 0, overflow flag 0, state RUN, drain counter 0.
- **Forwarding:** every cycle, `a_out`/`a_valid_out` ← `a_in`/`a_valid_in`, and likewise for B. This is unconditional, in every state.
- **MAC:** fires when `a_valid_in && b_valid_in`.
  - The product is full 2*DATA_WIDTH, sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH, then added.
  - If only one valid is high, the accumulator holds.
- **Overflow:**
  - SIGNED=1: detected when both addends have the same sign and the sum sign differs.
  - SIGNED=0: detected as carry-out.
  - On overflow, the sticky flag sets. With SATURATE=1 the result clamps to max/min signed, or to all-ones when unsigned.
- **Clear with a valid pair in the same cycle:** accumulator ← product; flag ← that product's overflow, which is always 0.
- **States:**
  - RUN: on `drain`, `c_out` ← accumulator (this cycle's product excluded), `c_ovf_out` ← flag, `c_valid_out` ← 1. The accumulator and flag are zeroed, and this cycle's valid product is loaded as the first term of the next tile. Go to DRAIN with counter 0, or stay in RUN if CHAIN_LEN=0. Otherwise `c_valid_out` ← 0.
  - DRAIN: `c_out`/`c_ovf_out`/`c_valid_out` ← `c_in`/`c_ovf_in`/`c_valid_in`. The counter increments on each `c_valid_in`. When `c_valid_in` arrives with counter = CHAIN_LEN-1, return to RUN.
  - MAC and `clear` remain active during DRAIN.
  - `drain` asserted during DRAIN is ignored.
- **Drain and clear in the same cycle (RUN):** the drain snapshot is taken first, then the accumulator is cleared. The result is identical to a drain alone.

## Timing
- A/B forwarding latency is 1 cycle.
- MAC result is visible in the accumulator 1 cycle after a valid pair.
- Own result appears on `c_out` 1 cycle after the `drain` pulse.
- Forwarded chain words have 1-cycle latency. A drain issued to a whole column at cycle t yields a contiguous burst of CHAIN_LEN+1 words at the bottom PE, starting at t+1.
- `busy` rises the cycle after `drain` and falls the cycle after the last forwarded word is registered.
- Reset mid-DRAIN aborts the drain immediately: `c_valid_out` and `busy` go to 0 asynchronously.

## Structure
- Package `systolic_pkg` holds:
  - the state enum (RUN, DRAIN);
  - the width-legality check constant for ACC_WIDTH ≥ 2*DATA_WIDTH;
  - a function computing the saturation bounds from ACC_WIDTH and SIGNED.
- Sub-module `pe_sat_acc` is combinational. It implements extend, add, overflow detection and clamp, taking accumulator and product in and returning sum and overflow out.
- The FSM, counter and pipeline registers live in `systolic_pe`.

## Test plan
Default parameters for all scenarios: DATA_WIDTH=8, ACC_WIDTH=20.

1. **Signed accumulate (SIGNED=1):** pairs (3,4), (-2,5), (7,7), then `drain` → `c_out`=51, `c_ovf_out`=0 one cycle later. `a_out`/`b_out` echo each operand with 1-cycle delay.
2. **Saturation (ACC_WIDTH=16, SATURATE=1):** (127,127) three times, then drain → `c_out`=32767, `c_ovf_out`=1. With SATURATE=0 → `c_out`=48387-65536=-17149, `c_ovf_out`=1.
3. **Clear with pair:** accumulator=100; `clear` together with (2,3) → accumulator=6. A single-sided valid (`a_valid_in` only) → accumulator unchanged.
4. **Drain chain (CHAIN_LEN=2):** own accumulator=9, drain at t → `c_out`=9 at t+1. `c_in`=11, 22 valid at t+1 and t+2 → `c_out`=11, 22 at t+2, t+3. A second drain at t+1 is ignored. `busy` is high from t+1 through t+3. A pair (4,4) at t → next drain emits 16.
5. **Unsigned (SIGNED=0):** (255,255) twice → 130050, no overflow.
6. **Reset:** `rst` asserted mid-DRAIN while `c_valid_in` is high → all outputs 0 and `busy`=0 without waiting for a clock edge. After release, the first drain emits 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and elaboration-time helpers for the systolic PE.
package systolic_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pe_state_t;

  // Widest accumulator the bound helper can describe.
  localparam int MAX_ACC_WIDTH = 128;

  // The accumulator must hold a full product without truncation.
  function automatic bit acc_width_ok(int data_width, int acc_width);
    return (acc_width >= 2 * data_width) && (acc_width <= MAX_ACC_WIDTH);
  endfunction

  typedef struct packed {
    logic [MAX_ACC_WIDTH-1:0] hi;
    logic [MAX_ACC_WIDTH-1:0] lo;
  } sat_bounds_t;

  // Clamp limits in the low acc_width bits: signed gives 0111..1 / 1000..0,
  // unsigned gives all-ones / zero.
  function automatic sat_bounds_t sat_bounds(int acc_width, bit is_signed);
    sat_bounds_t r;
    r.hi = '0;
    r.lo = '0;
    for (int i = 0; i < MAX_ACC_WIDTH; i++) begin
      if (i < acc_width - 1) begin
        r.hi[i] = 1'b1;
      end else if (i == acc_width - 1) begin
        r.hi[i] = !is_signed;
        r.lo[i] = is_signed;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_pe_if.sv
// Operand, control and result-chain signals of one processing element.
interface systolic_pe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
);
  logic [DATA_WIDTH-1:0] a_in;
  logic                  a_valid_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  b_valid_in;
  logic                  clear;
  logic                  drain;
  logic [ACC_WIDTH-1:0]  c_in;
  logic                  c_valid_in;
  logic                  c_ovf_in;
  logic [DATA_WIDTH-1:0] a_out;
  logic                  a_valid_out;
  logic [DATA_WIDTH-1:0] b_out;
  logic                  b_valid_out;
  logic [ACC_WIDTH-1:0]  c_out;
  logic                  c_valid_out;
  logic                  c_ovf_out;
  logic                  busy;

  // Array/controller side.
  modport master (
    output a_in, a_valid_in, b_in, b_valid_in, clear, drain,
           c_in, c_valid_in, c_ovf_in,
    input  a_out, a_valid_out, b_out, b_valid_out,
           c_out, c_valid_out, c_ovf_out, busy
  );

  // Processing-element side.
  modport slave (
    input  a_in, a_valid_in, b_in, b_valid_in, clear, drain,
           c_in, c_valid_in, c_ovf_in,
    output a_out, a_valid_out, b_out, b_valid_out,
           c_out, c_valid_out, c_ovf_out, busy
  );
endinterface

// File: rtl/pe_sat_acc.sv
// Combinational accumulate step: extend the product, add, detect overflow, clamp.
module pe_sat_acc
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic [ACC_WIDTH-1:0]    acc,
  input  logic [2*DATA_WIDTH-1:0] prod,
  output logic [ACC_WIDTH-1:0]    sum,
  output logic                    ovf
);

  localparam sat_bounds_t BOUNDS = sat_bounds(ACC_WIDTH, SIGNED != 0);
  localparam logic [ACC_WIDTH-1:0] SAT_HI = BOUNDS.hi[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] SAT_LO = BOUNDS.lo[ACC_WIDTH-1:0];

  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   raw;

  // Extend, add with carry, flag overflow and clamp toward the side it left.
  always_comb begin
    if (SIGNED != 0) begin
      addend = ACC_WIDTH'($signed(prod));
    end else begin
      addend = ACC_WIDTH'(prod);
    end
    raw = {1'b0, acc} + {1'b0, addend};
    if (SIGNED != 0) begin
      ovf = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
            (raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    end else begin
      ovf = raw[ACC_WIDTH];
    end
    sum = raw[ACC_WIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      if ((SIGNED != 0) && acc[ACC_WIDTH-1]) begin
        sum = SAT_LO;
      end else begin
        sum = SAT_HI;
      end
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary systolic PE: operand forwarding, MAC and result drain chain.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1,
  parameter int CHAIN_LEN  = 0
) (
  input  logic         clk,
  input  logic         rst,
  systolic_pe_if.slave pe
);

  localparam bit WIDTH_OK  = acc_width_ok(DATA_WIDTH, ACC_WIDTH);
  localparam int CNT_WIDTH = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CHAIN_LEN - 1);

  if (!WIDTH_OK) begin : g_bad_width
    $error("systolic_pe: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  pe_state_t               state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [ACC_WIDTH-1:0]    acc;
  logic                    ovf_flag;
  logic [2*DATA_WIDTH-1:0] a_ext;
  logic [2*DATA_WIDTH-1:0] b_ext;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    acc_base;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic                    sum_ovf;
  logic                    fire;
  logic                    take_drain;
  logic                    restart;

  assign fire       = pe.a_valid_in && pe.b_valid_in;
  assign take_drain = pe.drain && (state == RUN);
  // A drain snapshot starts a new tile exactly like a clear does.
  assign restart    = pe.clear || take_drain;
  assign acc_base   = restart ? '0 : acc;

  // Widen operands so the low 2*DATA_WIDTH bits of the product are exact.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = (2 * DATA_WIDTH)'($signed(pe.a_in));
      b_ext = (2 * DATA_WIDTH)'($signed(pe.b_in));
    end else begin
      a_ext = (2 * DATA_WIDTH)'(pe.a_in);
      b_ext = (2 * DATA_WIDTH)'(pe.b_in);
    end
  end

  assign prod = a_ext * b_ext;

  pe_sat_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_sat_acc (
    .acc (acc_base),
    .prod(prod),
    .sum (acc_sum),
    .ovf (sum_ovf)
  );

  // Unconditional one-cycle forwarding of operands east and south.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe.a_out       <= '0;
      pe.a_valid_out <= 1'b0;
      pe.b_out       <= '0;
      pe.b_valid_out <= 1'b0;
    end else begin
      pe.a_out       <= pe.a_in;
      pe.a_valid_out <= pe.a_valid_in;
      pe.b_out       <= pe.b_in;
      pe.b_valid_out <= pe.b_valid_in;
    end
  end

  // Accumulator and sticky overflow; a restart with a valid pair loads the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      ovf_flag <= 1'b0;
    end else if (fire) begin
      acc      <= acc_sum;
      ovf_flag <= (restart ? 1'b0 : ovf_flag) | sum_ovf;
    end else if (restart) begin
      acc      <= '0;
      ovf_flag <= 1'b0;
    end
  end

  // Drain FSM: emit own snapshot, then pass CHAIN_LEN words from above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      cnt            <= '0;
      pe.c_out       <= '0;
      pe.c_valid_out <= 1'b0;
      pe.c_ovf_out   <= 1'b0;
      pe.busy        <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (pe.drain) begin
            pe.c_out       <= acc;
            pe.c_ovf_out   <= ovf_flag;
            pe.c_valid_out <= 1'b1;
            if (CHAIN_LEN > 0) begin
              state   <= DRAIN;
              cnt     <= '0;
              pe.busy <= 1'b1;
            end else begin
              pe.busy <= 1'b0;
            end
          end else begin
            pe.c_valid_out <= 1'b0;
            pe.busy        <= 1'b0;
          end
        end
        DRAIN: begin
          pe.c_out       <= pe.c_in;
          pe.c_ovf_out   <= pe.c_ovf_in;
          pe.c_valid_out <= pe.c_valid_in;
          // Stays high one extra cycle so it covers the last forwarded word.
          pe.busy        <= 1'b1;
          if (pe.c_valid_in) begin
            if (cnt == CNT_LAST) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
